// File: rtl/wbi_pkg.sv
// Shared definitions for the W_B_I fetch-engine arbiter: requester indices,
// Buffer_Select codes and the sequencer state encoding.
package wbi_pkg;

    localparam int REQ_W = 0;
    localparam int REQ_B = 1;
    localparam int REQ_I = 2;

    localparam logic [2:0] BUF_NONE   = 3'd0;
    localparam logic [2:0] BUF_WEIGHT = 3'd1;
    localparam logic [2:0] BUF_BIAS   = 3'd2;
    localparam logic [2:0] BUF_INPUT  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_CNT,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  onehot_to_idx = 2'(REQ_B);
            3'b100:  onehot_to_idx = 2'(REQ_I);
            default: onehot_to_idx = 2'(REQ_W);
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker: the search starts at ptr and
// wraps modulo 3; the first active request wins.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic       any
);

    always_comb begin
        win = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd2: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
        any = |req;
    end

endmodule

// File: rtl/wbi_fetch_arbiter.sv
// Shares the W_B_I fetch engine between weight, bias and input loaders:
// round-robin grant, one start_fetch per tile, per-requester ping-pong bank.
module wbi_fetch_arbiter
    import wbi_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int TILE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*TILE_W-1:0] req_tiles,
    input  logic [NREQ*3-1:0]      req_buf_sel,
    input  logic [NREQ-1:0]        req_tiles_ctrl,
    input  logic                   layer_start,
    input  logic                   fetch_done,
    input  logic                   fetch_busy,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   start_fetch,
    output logic                   reset_addr_counter,
    output logic [2:0]             Buffer_Select,
    output logic                   Tiles_Control,
    output logic                   Double_buffering,
    output logic                   protocol_err
);

    state_t              state;
    logic [1:0]          ptr;
    logic [1:0]          cur;
    logic [TILE_W-1:0]   remaining;
    logic [NREQ-1:0]     bank;
    logic                pending;
    logic                busy_low_d;

    logic [2:0]          pick;
    logic                pick_any;
    logic [1:0]          pick_idx;
    logic [TILE_W-1:0]   pick_tiles;

    rr_arbiter3 u_rr (
        .req (req),
        .ptr (ptr),
        .win (pick),
        .any (pick_any)
    );

    assign pick_idx   = onehot_to_idx(pick);
    assign pick_tiles = req_tiles[pick_idx*TILE_W +: TILE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            ptr                <= 2'd0;
            cur                <= 2'd0;
            remaining          <= '0;
            bank               <= '0;
            pending            <= 1'b0;
            busy_low_d         <= 1'b0;
            gnt                <= '0;
            done               <= '0;
            start_fetch        <= 1'b0;
            reset_addr_counter <= 1'b0;
            Buffer_Select      <= 3'd0;
            Tiles_Control      <= 1'b0;
            Double_buffering   <= 1'b0;
            protocol_err       <= 1'b0;
        end else begin
            start_fetch        <= 1'b0;
            done               <= '0;
            reset_addr_counter <= 1'b0;
            if (layer_start)
                pending <= 1'b1;

            // A completion seen in the same cycle as its own start cannot be real.
            if (fetch_done && (state != ST_WAIT || start_fetch))
                protocol_err <= 1'b1;
            if (state == ST_WAIT && !fetch_busy && !fetch_done) begin
                if (busy_low_d)
                    protocol_err <= 1'b1;
                busy_low_d <= 1'b1;
            end else begin
                busy_low_d <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        reset_addr_counter <= 1'b1;
                        bank               <= '0;
                        state              <= ST_RST_CNT;
                    end else if (pick_any) begin
                        state <= ST_GRANT;
                    end
                end
                ST_RST_CNT: begin
                    pending <= layer_start;
                    state   <= ST_IDLE;
                end
                ST_GRANT: begin
                    if (!pick_any) begin
                        state <= ST_IDLE;
                    end else begin
                        gnt              <= pick;
                        cur              <= pick_idx;
                        Buffer_Select    <= req_buf_sel[pick_idx*3 +: 3];
                        Tiles_Control    <= req_tiles_ctrl[pick_idx];
                        remaining        <= pick_tiles;
                        Double_buffering <= bank[pick_idx];
                        ptr              <= (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
                        if (pick_tiles == '0) begin
                            done  <= pick;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    if (!fetch_busy) begin
                        start_fetch <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fetch_done && !start_fetch) begin
                        bank[cur]        <= ~bank[cur];
                        Double_buffering <= ~bank[cur];
                        remaining        <= remaining - TILE_W'(1);
                        if (remaining == TILE_W'(1)) begin
                            done  <= gnt;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_START;
                        end
                    end
                end
                ST_DONE: begin
                    gnt              <= '0;
                    Double_buffering <= 1'b0;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wbi_fetch_arbiter.md
# wbi_fetch_arbiter

Controller that shares the single W_B_I buffer fetch engine (fetch_logic_gen plus BRAM port B) between three requesters: weight, bias and input loaders. It round-robin arbitrates requests and sequences the fetch engine through a multi-tile burst. It issues one start_fetch per tile, toggles each requester's ping-pong bank between tiles, and returns a completion pulse. It also owns the engine's address-counter reset.

## Interface
- NREQ, 3, number of requesters (0 = weight, 1 = bias, 2 = input); fixed at 3 in this revision.
- TILE_W, 8, width of per-request tile count.
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until matching done.
- req_tiles  in  NREQ*TILE_W  tile count per requester, slice i at [i*TILE_W +: TILE_W]; sampled at grant.
- req_buf_sel  in  NREQ*3  Buffer_Select code per requester; sampled at grant.
- req_tiles_ctrl  in  NREQ  Tiles_Control value per requester; sampled at grant.
- layer_start  in  1  pulse; requests a fetch-engine address-counter reset.
- fetch_done  in  1  per-tile completion pulse from the fetch engine.
- fetch_busy  in  1  fetch engine busy.
- gnt  out  NREQ  one-hot grant, held for the whole burst.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- start_fetch  out  1  one-cycle pulse per tile.
- reset_addr_counter  out  1  one-cycle pulse.
- Buffer_Select  out  3  registered, held during burst.
- Tiles_Control  out  1  registered, held during burst.
- Double_buffering  out  1  bank bit of the current tile.
- protocol_err  out  1  sticky error flag.

## Operation
- States: IDLE, RST_CNT, GRANT, START, WAIT, DONE.
- IDLE, priority order:
  - If a layer_start is pending, go to RST_CNT.
  - Otherwise, if any req is high, go to GRANT.
- RST_CNT: assert reset_addr_counter for 1 cycle, clear all bank bits to 0, clear the pending flag, return to IDLE.
- layer_start pulses arriving in any state set a pending flag. Multiple pulses collapse into one reset, which is serviced only in IDLE. A burst is never interrupted.
- GRANT, round-robin:
  - Search from pointer ptr (reset 0) upward, modulo 3, and take the first high req.
  - Set gnt one-hot.
  - Latch the winner's tiles, buf_sel and tiles_ctrl into Buffer_Select and Tiles_Control.
  - Load remaining = tiles.
  - Set ptr = winner+1 mod 3.
  - If tiles == 0, go to DONE; otherwise go to START.
- START: wait until fetch_busy == 0, then pulse start_fetch for 1 cycle and go to WAIT.
- WAIT: on fetch_done:
  - Toggle bank[winner].
  - Decrement remaining.
  - If remaining becomes 0, go to DONE; else go to START.
- DONE: pulse done[winner] for 1 cycle, clear gnt, go to IDLE.
- Double_buffering = bank[winner] while gnt is set, else 0. Each requester keeps its own bank bit across bursts; only RST_CNT and reset clear it.
- req dropping mid-burst is ignored; the burst runs to completion. Input changes after grant have no effect.
- protocol_err is set on either condition below and cleared only by reset:
  - fetch_done outside WAIT;
  - fetch_busy low for 2 consecutive cycles in WAIT without fetch_done.
- Arithmetic: remaining is TILE_W bits, so the maximum burst is 2^TILE_W-1 tiles. There is no wrap, since a decrement never happens at 0.

## Timing
- Reset values:
  - gnt = 0, done = 0, start_fetch = 0, reset_addr_counter = 0;
  - Buffer_Select = 0, Tiles_Control = 0, Double_buffering = 0;
  - protocol_err = 0, ptr = 0, all bank bits = 0, state = IDLE.
- All outputs are registered.
- req high in IDLE at cycle n:
  - gnt is visible at n+2 (IDLE→GRANT, GRANT register);
  - the first start_fetch is at n+3 if fetch_busy = 0.
- fetch_done at cycle m, more tiles remaining: Double_buffering toggles at m+1 and the next start_fetch is at m+2.
- fetch_done at cycle m, last tile: done pulse at m+1 and gnt low at m+2.
- Back-to-back: after DONE, the next grant lands 2 cycles later.
- fetch_done coinciding with start_fetch is impossible by construction; if seen, it counts as outside WAIT and flags protocol_err.
- Async reset mid-burst: all outputs take reset values immediately; no done is issued for the aborted burst.

## Structure
- Shared package wbi_pkg:
  - requester index constants REQ_W = 0, REQ_B = 1, REQ_I = 2;
  - Buffer_Select code constants;
  - state enum.
- One sub-module: rr_arbiter3, a combinational round-robin picker (req, ptr → one-hot winner, any).

## Test plan
- Reset then single request: req = 3'b001, tiles = 2, buf_sel = 1 → gnt = 001, two start_fetch pulses, Double_buffering 0 then 1, one done[0] pulse, final bank[0] = 0.
- Round-robin fairness: req = 3'b111 held, tiles = 1 each → grant order 0, 1, 2, 0; ptr wraps correctly.
- Zero-tile request: req[1], tiles = 0 → done[1] with no start_fetch and no bank toggle.
- layer_start during a burst → reset_addr_counter pulses exactly once, only after DONE and before the next grant; all bank bits become 0.
- fetch_busy held high for 5 cycles in START → start_fetch is delayed until busy falls; spurious fetch_done in IDLE → protocol_err = 1 and stays set.
- rst_n asserted in WAIT → all outputs zero immediately; no done pulse after release.
